// File: rtl/msg_schedule_gen.sv
// +----------------------------------------------------------------------------+
// | msg_schedule_gen : SHA-2 message-schedule generator (rolling 16-word window) |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module msg_schedule_gen #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int IDX_W  = $clog2(ROUNDS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [16*WORD_W-1:0] blk_data,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [WORD_W-1:0]    w_data,
  output logic [IDX_W-1:0]     w_index,
  output logic                 w_last,
  output logic                 busy
);

  localparam logic [0:0]       c_idle     = 1'b0;
  localparam logic [0:0]       c_stream   = 1'b1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(ROUNDS - 1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [WORD_W-1:0] r_win [16];
  logic [IDX_W-1:0]  r_t;
  logic [WORD_W-1:0] w_sig0;
  logic [WORD_W-1:0] w_sig1;
  logic [WORD_W-1:0] w_new;
  logic              w_blk_fire;
  logic              w_out_fire;
  logic              w_at_last;

  generate
    if (ROUNDS < 16) begin : g_bad_rounds
      $error("msg_schedule_gen: ROUNDS must be >= 16");
    end

    if (WORD_W == 32) begin : g_sha256
      assign w_sig0 = {r_win[1][6:0],   r_win[1][31:7]}
                    ^ {r_win[1][17:0],  r_win[1][31:18]}
                    ^ (r_win[1] >> 3);
      assign w_sig1 = {r_win[14][16:0], r_win[14][31:17]}
                    ^ {r_win[14][18:0], r_win[14][31:19]}
                    ^ (r_win[14] >> 10);
    end else if (WORD_W == 64) begin : g_sha512
      assign w_sig0 = {r_win[1][0],     r_win[1][63:1]}
                    ^ {r_win[1][7:0],   r_win[1][63:8]}
                    ^ (r_win[1] >> 7);
      assign w_sig1 = {r_win[14][18:0], r_win[14][63:19]}
                    ^ {r_win[14][60:0], r_win[14][63:61]}
                    ^ (r_win[14] >> 6);
    end else begin : g_bad_word_w
      $error("msg_schedule_gen: WORD_W must be 32 or 64");
      assign w_sig0 = '0;
      assign w_sig1 = '0;
    end
  endgenerate

  // W[t+16]; words past ROUNDS-1 are computed but never presented
  assign w_new      = w_sig1 + r_win[9] + w_sig0 + r_win[0];
  assign w_blk_fire = (r_state == c_idle) && blk_valid;
  assign w_out_fire = (r_state == c_stream) && w_ready;
  assign w_at_last  = (r_t == c_last_idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:   if (blk_valid) w_state_nxt = c_stream;
      c_stream: if (w_ready && w_at_last) w_state_nxt = c_idle;
      default:  w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    blk_ready = (r_state == c_idle);
    w_valid   = (r_state == c_stream);
    busy      = (r_state == c_stream);
    w_data    = (r_state == c_stream) ? r_win[0] : '0;
    w_index   = r_t;
    w_last    = (r_state == c_stream) && w_at_last;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_t <= '0;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else if (w_blk_fire) begin
      r_t <= '0;
      for (int i = 0; i < 16; i++) r_win[i] <= blk_data[(16-i)*WORD_W-1 -: WORD_W];
    end else if (w_out_fire) begin
      if (w_at_last) begin
        r_t <= '0;
      end else begin
        r_t <= r_t + IDX_W'(1);
        for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
        r_win[15] <= w_new;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_msg_schedule_gen.sv
// +----------------------------------------------------------------------------+
// | tb_msg_schedule_gen : directed bench for SHA-256 and SHA-512 schedules       |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_msg_schedule_gen;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  logic         blk_valid32, blk_ready32, w_valid32, w_ready32, w_last32, busy32;
  logic [511:0] blk_data32;
  logic [31:0]  w_data32;
  logic [5:0]   w_index32;

  logic          blk_valid64, blk_ready64, w_valid64, w_ready64, w_last64, busy64;
  logic [1023:0] blk_data64;
  logic [63:0]   w_data64;
  logic [6:0]    w_index64;

  msg_schedule_gen #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clock(clock), .reset(reset),
    .blk_valid(blk_valid32), .blk_ready(blk_ready32), .blk_data(blk_data32),
    .w_valid(w_valid32), .w_ready(w_ready32), .w_data(w_data32),
    .w_index(w_index32), .w_last(w_last32), .busy(busy32)
  );

  msg_schedule_gen #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clock(clock), .reset(reset),
    .blk_valid(blk_valid64), .blk_ready(blk_ready64), .blk_data(blk_data64),
    .w_valid(w_valid64), .w_ready(w_ready64), .w_data(w_data64),
    .w_index(w_index64), .w_last(w_last64), .busy(busy64)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] e32 [64];
  logic [63:0] e64 [80];

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic build32(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) e32[i] = blk[(15-i)*32 +: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr32(e32[i-15], 7) ^ rotr32(e32[i-15], 18) ^ (e32[i-15] >> 3);
      s1 = rotr32(e32[i-2], 17) ^ rotr32(e32[i-2], 19) ^ (e32[i-2] >> 10);
      e32[i] = s1 + e32[i-7] + s0 + e32[i-16];
    end
  endtask

  task automatic build64(input logic [1023:0] blk);
    logic [63:0] s0, s1;
    for (int i = 0; i < 16; i++) e64[i] = blk[(15-i)*64 +: 64];
    for (int i = 16; i < 80; i++) begin
      s0 = rotr64(e64[i-15], 1) ^ rotr64(e64[i-15], 8) ^ (e64[i-15] >> 7);
      s1 = rotr64(e64[i-2], 19) ^ rotr64(e64[i-2], 61) ^ (e64[i-2] >> 6);
      e64[i] = s1 + e64[i-7] + s0 + e64[i-16];
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [1023:0] rand1024();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic start32(input logic [511:0] blk, input string tag);
    int cyc;
    cyc = 0;
    blk_valid32 = 1'b1;
    blk_data32  = blk;
    while (blk_ready32 !== 1'b1 && cyc < 200) begin
      @(posedge clock); #1; cyc++;
    end
    @(posedge clock); #1;
    blk_valid32 = 1'b0;
    blk_data32  = ~blk;
    n_cmp++;
    if (w_valid32 !== 1'b1 || w_index32 !== 6'd0) begin
      n_bad++;
      $display("FAIL %s latency32: w_valid=%b w_index=%0d, want 1 / 0", tag, w_valid32, w_index32);
    end
  endtask

  task automatic start64(input logic [1023:0] blk, input string tag);
    int cyc;
    cyc = 0;
    blk_valid64 = 1'b1;
    blk_data64  = blk;
    while (blk_ready64 !== 1'b1 && cyc < 200) begin
      @(posedge clock); #1; cyc++;
    end
    @(posedge clock); #1;
    blk_valid64 = 1'b0;
    blk_data64  = ~blk;
    n_cmp++;
    if (w_valid64 !== 1'b1 || w_index64 !== 7'd0) begin
      n_bad++;
      $display("FAIL %s latency64: w_valid=%b w_index=%0d, want 1 / 0", tag, w_valid64, w_index64);
    end
  endtask

  // Consumes one whole block; a stalled word must reappear unchanged next cycle
  task automatic stream32(input bit stall, input string tag);
    int got, cyc;
    bit rdy;
    got = 0; cyc = 0;
    while (got < 64 && cyc < 1000) begin
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      w_ready32 = rdy;
      n_cmp++;
      if (w_valid32 !== 1'b1) begin
        n_bad++; $display("FAIL %s valid32 idx=%0d: got %b want 1", tag, got, w_valid32);
      end
      n_cmp++;
      if (w_index32 !== 6'(got)) begin
        n_bad++; $display("FAIL %s index32: got %0d want %0d", tag, w_index32, got);
      end
      n_cmp++;
      if (w_data32 !== e32[got]) begin
        n_bad++; $display("FAIL %s data32 idx=%0d: got %h want %h", tag, got, w_data32, e32[got]);
      end
      n_cmp++;
      if (w_last32 !== 1'(got == 63)) begin
        n_bad++; $display("FAIL %s last32 idx=%0d: got %b want %b", tag, got, w_last32, got == 63);
      end
      @(posedge clock); #1;
      if (rdy) got++;
      cyc++;
    end
    w_ready32 = 1'b0;
    n_cmp++;
    if (got != 64) begin
      n_bad++; $display("FAIL %s count32: got %0d handshakes want 64", tag, got);
    end
    n_cmp++;
    if (w_valid32 !== 1'b0 || blk_ready32 !== 1'b1 || w_index32 !== 6'd0) begin
      n_bad++;
      $display("FAIL %s end32: valid=%b ready=%b idx=%0d want 0/1/0", tag, w_valid32, blk_ready32, w_index32);
    end
  endtask

  task automatic stream64(input bit stall, input string tag);
    int got, cyc;
    bit rdy;
    got = 0; cyc = 0;
    while (got < 80 && cyc < 1000) begin
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      w_ready64 = rdy;
      n_cmp++;
      if (w_valid64 !== 1'b1) begin
        n_bad++; $display("FAIL %s valid64 idx=%0d: got %b want 1", tag, got, w_valid64);
      end
      n_cmp++;
      if (w_index64 !== 7'(got)) begin
        n_bad++; $display("FAIL %s index64: got %0d want %0d", tag, w_index64, got);
      end
      n_cmp++;
      if (w_data64 !== e64[got]) begin
        n_bad++; $display("FAIL %s data64 idx=%0d: got %h want %h", tag, got, w_data64, e64[got]);
      end
      n_cmp++;
      if (w_last64 !== 1'(got == 79)) begin
        n_bad++; $display("FAIL %s last64 idx=%0d: got %b want %b", tag, got, w_last64, got == 79);
      end
      @(posedge clock); #1;
      if (rdy) got++;
      cyc++;
    end
    w_ready64 = 1'b0;
    n_cmp++;
    if (got != 80) begin
      n_bad++; $display("FAIL %s count64: got %0d handshakes want 80", tag, got);
    end
    n_cmp++;
    if (w_valid64 !== 1'b0 || blk_ready64 !== 1'b1 || w_index64 !== 7'd0) begin
      n_bad++;
      $display("FAIL %s end64: valid=%b ready=%b idx=%0d want 0/1/0", tag, w_valid64, blk_ready64, w_index64);
    end
  endtask

  function automatic logic [511:0] abc32();
    logic [511:0] b;
    b = '0;
    b[511:480] = 32'h61626380;
    b[31:0]    = 32'h00000018;
    return b;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    blk_valid32 = 1'b0; blk_data32 = '0; w_ready32 = 1'b0;
    blk_valid64 = 1'b0; blk_data64 = '0; w_ready64 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    n_cmp++;
    if (blk_ready32 !== 1'b1 || w_valid32 !== 1'b0 || busy32 !== 1'b0) begin
      n_bad++; $display("FAIL reset32 ctl: ready=%b valid=%b busy=%b want 1/0/0", blk_ready32, w_valid32, busy32);
    end
    n_cmp++;
    if (w_index32 !== 6'd0 || w_last32 !== 1'b0 || w_data32 !== 32'd0) begin
      n_bad++; $display("FAIL reset32 data: idx=%0d last=%b data=%h want 0/0/0", w_index32, w_last32, w_data32);
    end
    n_cmp++;
    if (blk_ready64 !== 1'b1 || w_valid64 !== 1'b0 || busy64 !== 1'b0 ||
        w_index64 !== 7'd0 || w_last64 !== 1'b0 || w_data64 !== 64'd0) begin
      n_bad++; $display("FAIL reset64: ready=%b valid=%b busy=%b idx=%0d data=%h want 1/0/0/0/0",
                        blk_ready64, w_valid64, busy64, w_index64, w_data64);
    end
  endtask

  task automatic test_abc32();
    build32(abc32());
    e32[16] = 32'h61626380;
    e32[17] = 32'h000F0000;
    e32[18] = 32'h7DA86405;
    e32[19] = 32'h600003C6;
    start32(abc32(), "abc32");
    n_cmp++;
    if (busy32 !== 1'b1 || blk_ready32 !== 1'b0) begin
      n_bad++; $display("FAIL abc32 busy: busy=%b ready=%b want 1/0", busy32, blk_ready32);
    end
    stream32(1'b0, "abc32");
  endtask

  task automatic test_stall32();
    build32(abc32());
    start32(abc32(), "stall32");
    stream32(1'b1, "stall32");
  endtask

  task automatic test_abc64();
    logic [1023:0] b;
    b = '0;
    b[1023:960] = 64'h6162638000000000;
    b[63:0]     = 64'h18;
    build64(b);
    e64[16] = 64'h6162638000000000;
    e64[17] = 64'h00030000000000C0;
    start64(b, "abc64");
    stream64(1'b0, "abc64");
  endtask

  task automatic test_back_to_back();
    logic [511:0] a, b;
    int t0;
    a = rand512();
    b = rand512();
    build32(a);
    blk_valid32 = 1'b1;
    blk_data32  = a;
    w_ready32   = 1'b1;
    @(posedge clock); #1;
    t0 = cyc_cnt;
    for (int k = 0; k < 64; k++) begin
      if (k == 5)  blk_data32 = rand512();
      if (k == 40) blk_data32 = b;
      n_cmp++;
      if (w_valid32 !== 1'b1 || w_index32 !== 6'(k) || w_data32 !== e32[k]) begin
        n_bad++; $display("FAIL b2b first idx=%0d: valid=%b index=%0d data=%h want data %h",
                          k, w_valid32, w_index32, w_data32, e32[k]);
      end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (w_valid32 !== 1'b0 || blk_ready32 !== 1'b1) begin
      n_bad++; $display("FAIL b2b bubble: valid=%b ready=%b want 0/1", w_valid32, blk_ready32);
    end
    build32(b);
    @(posedge clock); #1;
    blk_valid32 = 1'b0;
    n_cmp++;
    if (w_valid32 !== 1'b1 || w_data32 !== e32[0] || (cyc_cnt - t0) != 65) begin
      n_bad++; $display("FAIL b2b second W0: valid=%b data=%h spacing=%0d want 1/%h/65",
                        w_valid32, w_data32, cyc_cnt - t0, e32[0]);
    end
    stream32(1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    logic [511:0] a, b;
    a = rand512();
    b = rand512();
    build32(a);
    start32(a, "rstmid");
    w_ready32 = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      n_cmp++;
      if (w_data32 !== e32[k] || w_index32 !== 6'(k)) begin
        n_bad++; $display("FAIL rstmid pre idx=%0d: got %h/%0d want %h", k, w_data32, w_index32, e32[k]);
      end
      @(posedge clock); #1;
    end
    reset = 1'b1;
    blk_valid32 = 1'b1;
    blk_data32  = b;
    @(posedge clock); #1;
    n_cmp++;
    if (w_valid32 !== 1'b0 || blk_ready32 !== 1'b1 || w_index32 !== 6'd0 || busy32 !== 1'b0) begin
      n_bad++; $display("FAIL rstmid abort: valid=%b ready=%b idx=%0d busy=%b want 0/1/0/0",
                        w_valid32, blk_ready32, w_index32, busy32);
    end
    reset = 1'b0;
    blk_valid32 = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (w_valid32 !== 1'b0) begin
      n_bad++; $display("FAIL rstmid capture-in-reset: valid=%b want 0", w_valid32);
    end
    build32(b);
    start32(b, "rstmid_new");
    stream32(1'b0, "rstmid_new");
  endtask

  task automatic test_random();
    logic [511:0]  b32;
    logic [1023:0] b64;
    for (int n = 0; n < 2; n++) begin
      b32 = rand512();
      build32(b32);
      start32(b32, "rand32");
      stream32(n[0], "rand32");
      b64 = rand1024();
      build64(b64);
      start64(b64, "rand64");
      stream64(n[0], "rand64");
    end
  endtask

  initial begin
    test_reset();
    test_abc32();
    test_stall32();
    test_abc64();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
